// File: rtl/toggle_encoder_pkg.sv
// Shared definitions for the toggle-encoded transmit path and its receiver-side counter.
package toggle_encoder_pkg;

    localparam int N_BITS = 64;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/toggle_encoder_ones_counter.sv
// Up-counter with synchronous clear and enable; clear has priority over enable.
module toggle_encoder_ones_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/toggle_encoder.sv
// Serialises an n-bit word MSB-first as a differential (toggle) stream and counts its '1' bits.
module toggle_encoder
    import toggle_encoder_pkg::*;
#(
    parameter int n = N_BITS,
    parameter int h = CNT_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] par_in,
    output logic         D,
    output logic         valid,
    output logic         busy,
    output logic         done,
    output logic [h-1:0] ones
);

    localparam int IDX_W = (n > 1) ? $clog2(n) : 1;

    generate
        if ((2 ** h) <= n) begin : g_width_check
            $error("toggle_encoder: 2**h must exceed n so the ones count cannot wrap");
        end
    endgenerate

    state_e           state_q;
    logic [n-1:0]     sr_q;
    logic             qm_q;
    logic             d_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic [IDX_W-1:0] idx;
    logic             accept;
    logic             in_shift;
    logic             bit_b;
    logic             last_bit;

    assign accept   = (state_q == IDLE) && start;
    assign in_shift = (state_q == SHIFT);
    assign bit_b    = sr_q[n-1];
    assign last_bit = (idx == IDX_W'(n - 1));

    toggle_encoder_ones_counter #(.W(h)) u_ones (
        .clock (clock),
        .reset (reset),
        .clr   (accept),
        .en    (in_shift && bit_b),
        .count (ones)
    );

    toggle_encoder_ones_counter #(.W(IDX_W)) u_bit_idx (
        .clock (clock),
        .reset (reset),
        .clr   (accept),
        .en    (in_shift),
        .count (idx)
    );

    // qm_q mirrors the receiver's toggle flip-flop, so it survives frame boundaries.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            qm_q    <= 1'b0;
            d_q     <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    d_q     <= 1'b0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (start) begin
                        sr_q    <= par_in;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    d_q     <= bit_b ^ qm_q;
                    qm_q    <= bit_b;
                    sr_q    <= sr_q << 1;
                    valid_q <= 1'b1;
                    if (last_bit) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    d_q     <= 1'b0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    d_q     <= 1'b0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign D     = d_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
